// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchroniser plus an independent debounce FSM per
// push-button. Produces a clean registered level and a one-cycle press pulse
// per channel, so downstream loading logic sees each physical press once.
module button_debouncer #(
  parameter int NB_BUTTONS      = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NB_COUNTER      = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NB_BUTTONS-1:0] i_buttons,
  output logic [NB_BUTTONS-1:0] o_level,
  output logic [NB_BUTTONS-1:0] o_pulse
);

  // Channel FSM encoding.
  localparam logic [1:0] ST_LOW       = 2'd0;
  localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

  // Last count value of a stability window; the counter never goes past it.
  localparam logic [NB_COUNTER-1:0] CNT_LAST = NB_COUNTER'(DEBOUNCE_CYCLES - 1);

  logic [NB_BUTTONS-1:0] meta_q;
  logic [NB_BUTTONS-1:0] sync_q;

  // Two-flop synchroniser; sync_q is the only view of the buttons the FSMs use.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= i_buttons;
      sync_q <= meta_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NB_BUTTONS; gi++) begin : g_chan
      logic [1:0]            state_q, state_d;
      logic [NB_COUNTER-1:0] cnt_q, cnt_d;
      logic                  level_q, level_d;
      logic                  pulse_q, pulse_d;
      logic                  s;

      assign s = sync_q[gi];

      // Next-state logic: an opposite sample in a WAIT state falls back to the
      // settled state, so any bounce restarts the acceptance window.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        case (state_q)
          ST_LOW: begin
            if (s) begin
              state_d = ST_WAIT_HIGH;
              cnt_d   = '0;
            end
          end
          ST_WAIT_HIGH: begin
            if (!s) begin
              state_d = ST_LOW;
              cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
              state_d = ST_HIGH;
              level_d = 1'b1;
              pulse_d = 1'b1;
            end else begin
              cnt_d = cnt_q + NB_COUNTER'(1);
            end
          end
          ST_HIGH: begin
            if (!s) begin
              state_d = ST_WAIT_LOW;
              cnt_d   = '0;
            end
          end
          ST_WAIT_LOW: begin
            if (s) begin
              state_d = ST_HIGH;
              cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
              state_d = ST_LOW;
              level_d = 1'b0;
            end else begin
              cnt_d = cnt_q + NB_COUNTER'(1);
            end
          end
          default: begin
            state_d = ST_LOW;
            cnt_d   = '0;
            level_d = 1'b0;
          end
        endcase
      end

      // Channel state registers; reset aborts any count in progress.
      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
          state_q <= ST_LOW;
          cnt_q   <= '0;
          level_q <= 1'b0;
          pulse_q <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          level_q <= level_d;
          pulse_q <= pulse_d;
        end
      end

      assign o_level[gi] = level_q;
      assign o_pulse[gi] = pulse_q;
    end
  endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// Testbench for button_debouncer with 3 channels and a 4-cycle debounce window.
module tb_button_debouncer;

  localparam int NB = 3;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn = '0;
  logic [NB-1:0] o_level;
  logic [NB-1:0] o_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int pcnt [NB];

  button_debouncer #(
    .NB_BUTTONS     (NB),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .i_clock  (clk),
    .i_reset  (rst),
    .i_buttons(btn),
    .o_level  (o_level),
    .o_pulse  (o_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the debounced view is the raw input delayed two edges;
  // a new level is accepted once D+1 consecutive samples disagree with it.
  logic [NB-1:0] m_d1, m_d2, m_lvl, m_pls;
  int            m_run [NB];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_d1  <= '0;
      m_d2  <= '0;
      m_lvl <= '0;
      m_pls <= '0;
      for (int i = 0; i < NB; i++) m_run[i] <= 0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (m_d2[i] != m_lvl[i]) begin
          if (m_run[i] + 1 == D + 1) begin
            m_lvl[i] <= m_d2[i];
            m_pls[i] <= m_d2[i];
            m_run[i] <= 0;
          end else begin
            m_run[i] <= m_run[i] + 1;
            m_pls[i] <= 1'b0;
          end
        end else begin
          m_run[i] <= 0;
          m_pls[i] <= 1'b0;
        end
      end
      m_d1 <= btn;
      m_d2 <= m_d1;
    end
  end

  // Per-cycle comparison against the model, plus a pulse tally per channel.
  always @(negedge clk) begin
    chk("model_level", 32'(o_level), 32'(m_lvl));
    chk("model_pulse", 32'(o_pulse), 32'(m_pls));
    for (int i = 0; i < NB; i++) pcnt[i] += int'(o_pulse[i]);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NB; i++) pcnt[i] = 0;

    // Reset then idle
    rst = 1'b1;
    btn = '0;
    repeat (3) begin
      tick();
      chk("rst_level", 32'(o_level), 32'h0);
      chk("rst_pulse", 32'(o_pulse), 32'h0);
    end
    rst = 1'b0;
    repeat (4) tick();
    chk("idle_level", 32'(o_level), 32'h0);
    chk("idle_pulse", 32'(o_pulse), 32'h0);
    $display("txn reset/idle done");

    // Clean press on channel 0, held 20 cycles
    btn = 3'b001;
    repeat (6) tick();
    chk("press_pre_level", 32'(o_level[0]), 32'h0);
    tick();
    chk("press_level", 32'(o_level[0]), 32'h1);
    chk("press_pulse", 32'(o_pulse[0]), 32'h1);
    tick();
    chk("press_pulse_end", 32'(o_pulse[0]), 32'h0);
    repeat (12) tick();
    chk("press_held_level", 32'(o_level[0]), 32'h1);
    chk("press_held_pulses", 32'(pcnt[0]), 32'd1);
    btn = 3'b000;
    repeat (10) tick();
    chk("press_release_level", 32'(o_level[0]), 32'h0);
    $display("txn clean press ch0 done");

    // Bounce rejection on channel 1
    for (int i = 0; i < 4; i++) begin
      btn[1] = (i % 2 == 0);
      repeat (2) begin
        tick();
        chk("bounce_level", 32'(o_level[1]), 32'h0);
      end
    end
    btn[1] = 1'b1;
    repeat (6) tick();
    chk("bounce_pre_pulse", 32'(o_pulse[1]), 32'h0);
    tick();
    chk("bounce_pulse", 32'(o_pulse[1]), 32'h1);
    chk("bounce_level_up", 32'(o_level[1]), 32'h1);
    repeat (4) tick();
    chk("bounce_pulses", 32'(pcnt[1]), 32'd1);
    $display("txn bounce ch1 done");

    // Release debounce on channel 2
    btn[2] = 1'b1;
    repeat (8) tick();
    chk("rel_setup_level", 32'(o_level[2]), 32'h1);
    btn[2] = 1'b0;
    repeat (3) tick();
    btn[2] = 1'b1;
    repeat (12) begin
      tick();
      chk("rel_glitch_level", 32'(o_level[2]), 32'h1);
    end
    chk("rel_glitch_pulses", 32'(pcnt[2]), 32'd1);
    btn[2] = 1'b0;
    repeat (6) tick();
    chk("rel_pre_level", 32'(o_level[2]), 32'h1);
    tick();
    chk("rel_level", 32'(o_level[2]), 32'h0);
    repeat (4) tick();
    chk("rel_pulses", 32'(pcnt[2]), 32'd1);
    btn = 3'b000;
    repeat (10) tick();
    chk("all_released", 32'(o_level), 32'h0);
    $display("txn release ch2 done");

    // Simultaneous press on all channels
    btn = 3'b111;
    repeat (6) tick();
    chk("sim_pre_pulse", 32'(o_pulse), 32'h0);
    tick();
    chk("sim_pulse", 32'(o_pulse), 32'h7);
    chk("sim_level", 32'(o_level), 32'h7);
    tick();
    chk("sim_pulse_end", 32'(o_pulse), 32'h0);
    btn = 3'b000;
    repeat (10) tick();
    chk("sim_pulses0", 32'(pcnt[0]), 32'd2);
    chk("sim_pulses1", 32'(pcnt[1]), 32'd2);
    chk("sim_pulses2", 32'(pcnt[2]), 32'd2);
    $display("txn simultaneous press done");

    // Reset in the middle of an acceptance window, button held throughout
    btn = 3'b001;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("midrst_level", 32'(o_level), 32'h0);
    chk("midrst_pulse", 32'(o_pulse), 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("midrst_pre_pulse", 32'(o_pulse[0]), 32'h0);
    tick();
    chk("midrst_pulse_after", 32'(o_pulse[0]), 32'h1);
    chk("midrst_level_after", 32'(o_level[0]), 32'h1);
    tick();
    chk("midrst_pulses", 32'(pcnt[0]), 32'd3);
    $display("txn reset mid-count done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
